store_unit: RTL

Multicycle store path of the processor: the write-direction counterpart of the memory-to-register write-back selection. On a store instruction (sw/sh/sb) the control unit pulses `start`, and the block performs the memory transaction. For sw it writes the register word directly. For sh/sb it reads the containing word, merges the register's low half or byte into the addressed lane, and writes the result back. It sits between the register file's B output, the address register (ALUOut) and the single-port data memory, and reports completion to the control FSM.

---
 rtl/store_unit_pkg.sv | 25 ++
 rtl/store_unit_merge.sv | 23 ++
 rtl/store_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// Shared encodings for the store path: store-size codes and FSM states.
// Also holds the alignment rule applied when STORE_ALIGN_CHECK_EN is defined.
package store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_WORD) && (lane != 2'b00)) ||
               ((size == SZ_HALF) && lane[0]);
    endfunction

endpackage

// File: rtl/store_unit_merge.sv
// Combinational lane merge: places the register's low half/byte into the read word.
// Word size passes the register through; reserved size returns the read word.
module store_merge
    import store_unit_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_reg_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = i_rd_word;
        case (size_e'(i_size))
            SZ_WORD: o_word = i_reg_data;
            SZ_HALF: o_word[{i_lane[1], 4'b0000} +: 16] = i_reg_data[15:0];
            SZ_BYTE: o_word[{i_lane, 3'b000} +: 8]      = i_reg_data[7:0];
            default: o_word = i_rd_word;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Multicycle sw/sh/sb path: sw writes in 1 cycle, sh/sb read-merge-write after MEM_RD_LAT cycles.
// Starts arriving while busy are dropped; STORE_ALIGN_CHECK_EN adds the misaligned FAULT path.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int MEM_RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_size,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LAT - 1);

    state_e      r_state;
    logic [2:0]  r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [31:0] r_data;
    logic [31:0] r_buf;
    logic [31:0] r_mem_addr;
    logic        r_mem_wr;
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_merged;

`ifdef STORE_ALIGN_CHECK_EN
    logic r_misaligned;
    logic w_fault;
    assign w_fault    = is_misaligned(store_size, addr[1:0]);
    assign misaligned = r_misaligned;
`else
    assign misaligned = 1'b0;
`endif

    store_merge u_merge (
        .i_rd_word  (r_buf),
        .i_reg_data (r_data),
        .i_size     (r_size),
        .i_lane     (r_lane),
        .o_word     (w_merged)
    );

    assign mem_addr  = r_mem_addr;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wr ? w_merged : 32'h0;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_data     <= 32'h0;
            r_buf      <= 32'h0;
            r_mem_addr <= 32'h0;
            r_mem_wr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_size <= store_size;
                        r_lane <= addr[1:0];
                        r_data <= reg_data;
                        r_busy <= 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
                        if (w_fault) begin
                            r_state      <= ST_FAULT;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else
`endif
                        begin
                            case (size_e'(store_size))
                                SZ_WORD: begin
                                    r_state    <= ST_WRITE;
                                    r_mem_addr <= {addr[31:2], 2'b00};
                                    r_mem_wr   <= 1'b1;
                                end
                                SZ_HALF, SZ_BYTE: begin
                                    r_state    <= ST_READ;
                                    r_mem_addr <= {addr[31:2], 2'b00};
                                    r_cnt      <= LAT_M1;
                                end
                                default: begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_READ: begin
                    // Read data is only guaranteed on the final READ cycle.
                    if (r_cnt == 3'd0) begin
                        r_buf    <= mem_rdata;
                        r_mem_wr <= 1'b1;
                        r_state  <= ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WRITE: begin
                    r_mem_wr   <= 1'b0;
                    r_mem_addr <= 32'h0;
                    r_done     <= 1'b1;
                    r_state    <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
